// File: rtl/lieat_axi_sram.sv
// AXI-lite style SRAM responder: word array with independent read/write FSMs and programmable latency.
// Optional misalignment checking is compiled in with `define LIEAT_SRAM_MISALIGN_CHK_EN.
`ifndef XLEN
`define XLEN 32
`endif

module lieat_axi_sram #(
  parameter int unsigned AW_WORDS  = 12,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned WR_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sram_axi_arvalid,
  output logic              sram_axi_arready,
  input  logic [`XLEN-1:0]  sram_axi_araddr,
  input  logic [2:0]        sram_axi_arsize,
  input  logic [3:0]        sram_axi_arid,
  output logic              sram_axi_rvalid,
  input  logic              sram_axi_rready,
  output logic [`XLEN-1:0]  sram_axi_rdata,
  output logic [3:0]        sram_axi_rid,
  input  logic              sram_axi_awvalid,
  output logic              sram_axi_awready,
  input  logic [`XLEN-1:0]  sram_axi_awaddr,
  input  logic [2:0]        sram_axi_awsize,
  input  logic [3:0]        sram_axi_awid,
  input  logic              sram_axi_wvalid,
  output logic              sram_axi_wready,
  input  logic [`XLEN-1:0]  sram_axi_wdata,
  output logic              sram_axi_bvalid,
  input  logic              sram_axi_bready,
  output logic [1:0]        sram_axi_bresp,
  output logic [3:0]        sram_axi_bid
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_WAIT = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam int unsigned RCW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned WCW   = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam int unsigned DEPTH = 1 << AW_WORDS;

  logic [31:0]          r_mem [DEPTH];

  logic [1:0]           r_rstate;
  logic [RCW-1:0]       r_rcnt;
  logic [`XLEN-1:0]     r_rdata;
  logic [3:0]           r_rid;

  logic [1:0]           r_wstate;
  logic [WCW-1:0]       r_wcnt;
  logic [31:0]          r_awaddr;
  logic [2:0]           r_awsize;
  logic [3:0]           r_bid;
  logic [1:0]           r_bresp;

  logic [31:0]          w_roff;
  logic                 w_rin_range;
  logic [AW_WORDS-1:0]  w_ridx;
  logic                 w_rmis;
  logic [31:0]          w_rword;

  logic [31:0]          w_woff;
  logic                 w_win_range;
  logic [AW_WORDS-1:0]  w_widx;
  logic                 w_wmis;
  logic                 w_wok;
  logic [3:0]           w_mask;
  logic                 w_commit;
  logic                 w_unused;

  // ---------------- read path ----------------
  assign w_roff      = sram_axi_araddr[31:0] - BASE_ADDR;
  assign w_rin_range = (w_roff[31:AW_WORDS+2] == '0);
  assign w_ridx      = w_roff[AW_WORDS+1:2];

`ifdef LIEAT_SRAM_MISALIGN_CHK_EN
  assign w_rmis = (sram_axi_arsize > 3'd2) ||
                  ((sram_axi_arsize == 3'd1) && sram_axi_araddr[0]) ||
                  ((sram_axi_arsize == 3'd2) && (sram_axi_araddr[1:0] != 2'b00));
`else
  assign w_rmis = 1'b0;
`endif

  always_comb begin
    w_rword = '0;
    if (w_rmis)
      w_rword = 32'hDEAD_BEEF;
    else if (w_rin_range)
      w_rword = r_mem[w_ridx];
  end

  // Array is sampled at the AR handshake edge, so a same-edge write commit is not seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rstate <= R_IDLE;
      r_rcnt   <= '0;
      r_rdata  <= '0;
      r_rid    <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (sram_axi_arvalid) begin
            r_rid   <= sram_axi_arid;
            r_rdata <= w_rword;
            if (RD_LAT == 1) begin
              r_rstate <= R_RESP;
            end else begin
              r_rcnt   <= RCW'(RD_LAT - 1);
              r_rstate <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          r_rcnt <= r_rcnt - RCW'(1);
          if (r_rcnt == RCW'(1))
            r_rstate <= R_RESP;
        end
        R_RESP: begin
          if (sram_axi_rready)
            r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign sram_axi_arready = (r_rstate == R_IDLE);
  assign sram_axi_rvalid  = (r_rstate == R_RESP);
  assign sram_axi_rdata   = r_rdata;
  assign sram_axi_rid     = r_rid;

  // ---------------- write path ----------------
  assign w_woff      = r_awaddr - BASE_ADDR;
  assign w_win_range = (w_woff[31:AW_WORDS+2] == '0);
  assign w_widx      = w_woff[AW_WORDS+1:2];

`ifdef LIEAT_SRAM_MISALIGN_CHK_EN
  assign w_wmis = (r_awsize > 3'd2) ||
                  ((r_awsize == 3'd1) && r_awaddr[0]) ||
                  ((r_awsize == 3'd2) && (r_awaddr[1:0] != 2'b00));
`else
  assign w_wmis = 1'b0;
`endif

  assign w_wok = w_win_range && !w_wmis;

  always_comb begin
    w_mask = 4'b1111;
    case (r_awsize)
      3'd0:    w_mask = 4'b0001 << r_awaddr[1:0];
      3'd1:    w_mask = 4'b0011 << {r_awaddr[1], 1'b0};
      default: w_mask = 4'b1111;
    endcase
  end

  assign w_commit = rst_n && (r_wstate == W_DATA) && sram_axi_wvalid && w_wok;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_mask[b])
          r_mem[w_widx][8*b +: 8] <= sram_axi_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wstate <= W_IDLE;
      r_wcnt   <= '0;
      r_awaddr <= '0;
      r_awsize <= '0;
      r_bid    <= '0;
      r_bresp  <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (sram_axi_awvalid) begin
            r_awaddr <= sram_axi_awaddr[31:0];
            r_awsize <= sram_axi_awsize;
            r_bid    <= sram_axi_awid;
            r_wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (sram_axi_wvalid) begin
            r_bresp <= w_wok ? 2'b00 : 2'b10;
            if (WR_LAT == 1) begin
              r_wstate <= W_RESP;
            end else begin
              r_wcnt   <= WCW'(WR_LAT - 1);
              r_wstate <= W_WAIT;
            end
          end
        end
        W_WAIT: begin
          r_wcnt <= r_wcnt - WCW'(1);
          if (r_wcnt == WCW'(1))
            r_wstate <= W_RESP;
        end
        W_RESP: begin
          if (sram_axi_bready)
            r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  assign sram_axi_awready = (r_wstate == W_IDLE);
  assign sram_axi_wready  = (r_wstate == W_DATA);
  assign sram_axi_bvalid  = (r_wstate == W_RESP);
  assign sram_axi_bresp   = r_bresp;
  assign sram_axi_bid     = r_bid;

  assign w_unused = &{1'b0, sram_axi_arsize, w_roff[1:0], w_woff[1:0]};

endmodule

// File: tb/tb_lieat_axi_sram.sv
// Bench for lieat_axi_sram: two instances (fast and slow latency) checked against a byte-level memory model.
module tb_lieat_axi_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        arvalid [2], arready [2], rvalid [2], rready [2];
  logic        awvalid [2], awready [2], wvalid [2], wready [2], bvalid [2], bready [2];
  logic [31:0] araddr [2], rdata [2], awaddr [2], wdata [2];
  logic [2:0]  arsize [2], awsize [2];
  logic [3:0]  arid [2], rid [2], awid [2], bid [2];
  logic [1:0]  bresp [2];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mdl [2][4096];

  lieat_axi_sram #(.AW_WORDS(12), .BASE_ADDR(BASE), .RD_LAT(1), .WR_LAT(1)) u_fast (
    .clk(clk), .rst_n(rst_n),
    .sram_axi_arvalid(arvalid[0]), .sram_axi_arready(arready[0]), .sram_axi_araddr(araddr[0]),
    .sram_axi_arsize(arsize[0]), .sram_axi_arid(arid[0]),
    .sram_axi_rvalid(rvalid[0]), .sram_axi_rready(rready[0]), .sram_axi_rdata(rdata[0]), .sram_axi_rid(rid[0]),
    .sram_axi_awvalid(awvalid[0]), .sram_axi_awready(awready[0]), .sram_axi_awaddr(awaddr[0]),
    .sram_axi_awsize(awsize[0]), .sram_axi_awid(awid[0]),
    .sram_axi_wvalid(wvalid[0]), .sram_axi_wready(wready[0]), .sram_axi_wdata(wdata[0]),
    .sram_axi_bvalid(bvalid[0]), .sram_axi_bready(bready[0]), .sram_axi_bresp(bresp[0]), .sram_axi_bid(bid[0])
  );

  lieat_axi_sram #(.AW_WORDS(12), .BASE_ADDR(BASE), .RD_LAT(4), .WR_LAT(3)) u_slow (
    .clk(clk), .rst_n(rst_n),
    .sram_axi_arvalid(arvalid[1]), .sram_axi_arready(arready[1]), .sram_axi_araddr(araddr[1]),
    .sram_axi_arsize(arsize[1]), .sram_axi_arid(arid[1]),
    .sram_axi_rvalid(rvalid[1]), .sram_axi_rready(rready[1]), .sram_axi_rdata(rdata[1]), .sram_axi_rid(rid[1]),
    .sram_axi_awvalid(awvalid[1]), .sram_axi_awready(awready[1]), .sram_axi_awaddr(awaddr[1]),
    .sram_axi_awsize(awsize[1]), .sram_axi_awid(awid[1]),
    .sram_axi_wvalid(wvalid[1]), .sram_axi_wready(wready[1]), .sram_axi_wdata(wdata[1]),
    .sram_axi_bvalid(bvalid[1]), .sram_axi_bready(bready[1]), .sram_axi_bresp(bresp[1]), .sram_axi_bid(bid[1])
  );

  function automatic int rd_lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int wr_lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off / 4) < 4096;
  endfunction

  function automatic bit misal(input logic [31:0] a, input logic [2:0] s);
`ifdef LIEAT_SRAM_MISALIGN_CHK_EN
    return (s > 3'd2) || (s == 3'd1 && (a % 2) != 0) || (s == 3'd2 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] mdl_rd(input int d, input logic [31:0] a, input logic [2:0] s);
    logic [31:0] off;
    off = a - BASE;
    if (misal(a, s)) return 32'hDEAD_BEEF;
    if (!in_rng(a)) return 32'h0;
    return mdl[d][off / 4];
  endfunction

  // Applies a write to the model and returns the response the responder should give.
  function automatic logic [1:0] mdl_wr(input int d, input logic [31:0] a, input logic [2:0] s,
                                        input logic [31:0] wd);
    logic [31:0] off;
    int unsigned nbytes, lane, start;
    if (!in_rng(a) || misal(a, s)) return 2'b10;
    off    = a - BASE;
    nbytes = 1 << ((s > 3'd2) ? 2 : int'(s));
    lane   = a % 4;
    start  = lane - (lane % nbytes);
    for (int unsigned b = 0; b < 4; b++)
      if (b >= start && b < start + nbytes)
        mdl[d][off / 4][8*b +: 8] = wd[8*b +: 8];
    return 2'b00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input int d, input logic [31:0] a, input logic [2:0] s, input logic [3:0] id,
                         input int hold, output logic [31:0] data, output logic [3:0] rid_o,
                         output int lat);
    int n;
    arvalid[d] = 1'b1; araddr[d] = a; arsize[d] = s; arid[d] = id;
    n = 0;
    while (arready[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("ar_wait", 32'(n < 20), 32'd1);
    @(negedge clk);
    arvalid[d] = 1'b0;
    lat = 1;
    while (rvalid[d] !== 1'b1 && lat < 20) begin
      check("ar_busy", 32'(arready[d]), 32'd0);
      @(negedge clk);
      lat++;
    end
    data = rdata[d]; rid_o = rid[d];
    for (int i = 0; i < hold; i++) begin
      check("r_hold", 32'(rvalid[d]), 32'd1);
      check("ar_busy_hold", 32'(arready[d]), 32'd0);
      @(negedge clk);
      check("r_stable", rdata[d], data);
    end
    rready[d] = 1'b1;
    @(negedge clk);
    rready[d] = 1'b0;
    check("r_drop", 32'(rvalid[d]), 32'd0);
  endtask

  task automatic do_write(input int d, input logic [31:0] a, input logic [2:0] s, input logic [3:0] id,
                          input logic [31:0] wd, input int hold, output logic [1:0] br,
                          output logic [3:0] bid_o, output int lat);
    int n;
    check("w_idle_wready", 32'(wready[d]), 32'd0);
    awvalid[d] = 1'b1; awaddr[d] = a; awsize[d] = s; awid[d] = id;
    n = 0;
    while (awready[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("aw_wait", 32'(n < 20), 32'd1);
    @(negedge clk);
    awvalid[d] = 1'b0;
    wvalid[d] = 1'b1; wdata[d] = wd;
    n = 0;
    while (wready[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("w_wait", 32'(n < 20), 32'd1);
    @(negedge clk);
    wvalid[d] = 1'b0;
    lat = 1;
    while (bvalid[d] !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    br = bresp[d]; bid_o = bid[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("b_hold", 32'(bvalid[d]), 32'd1);
    end
    bready[d] = 1'b1;
    @(negedge clk);
    bready[d] = 1'b0;
    check("b_drop", 32'(bvalid[d]), 32'd0);
  endtask

  task automatic wr_chk(input int d, input logic [31:0] a, input logic [2:0] s, input logic [3:0] id,
                        input logic [31:0] wd, input int hold);
    logic [1:0] br, exp_br;
    logic [3:0] gid;
    int lat;
    exp_br = mdl_wr(d, a, s, wd);
    do_write(d, a, s, id, wd, hold, br, gid, lat);
    check("bresp", 32'(br), 32'(exp_br));
    check("bid", 32'(gid), 32'(id));
    check("b_lat", 32'(lat), 32'(wr_lat(d)));
  endtask

  task automatic rd_chk(input int d, input logic [31:0] a, input logic [2:0] s, input logic [3:0] id,
                        input int hold);
    logic [31:0] got;
    logic [3:0] gid;
    int lat;
    do_read(d, a, s, id, hold, got, gid, lat);
    check("rdata", got, mdl_rd(d, a, s));
    check("rid", 32'(gid), 32'(id));
    check("r_lat", 32'(lat), 32'(rd_lat(d)));
  endtask

  initial begin
    logic [31:0] a, old_w, new_w;
    logic [2:0]  s;
    int          r;

    for (int d = 0; d < 2; d++) begin
      arvalid[d] = 0; rready[d] = 0; awvalid[d] = 0; wvalid[d] = 0; bready[d] = 0;
      araddr[d] = '0; arsize[d] = '0; arid[d] = '0;
      awaddr[d] = '0; awsize[d] = '0; awid[d] = '0; wdata[d] = '0;
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check("rst_rdata", rdata[d], 32'h0);
      check("rst_rid", 32'(rid[d]), 32'd0);
      check("rst_bid", 32'(bid[d]), 32'd0);
      check("rst_bresp", 32'(bresp[d]), 32'd0);
    end
    for (int c = 0; c < 10; c++) begin
      for (int d = 0; d < 2; d++) begin
        check("idle_arready", 32'(arready[d]), 32'd1);
        check("idle_awready", 32'(awready[d]), 32'd1);
        check("idle_wready", 32'(wready[d]), 32'd0);
        check("idle_rvalid", 32'(rvalid[d]), 32'd0);
        check("idle_bvalid", 32'(bvalid[d]), 32'd0);
      end
      @(negedge clk);
    end

    // Known contents for the words the rest of the run touches.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) wr_chk(d, BASE + 32'(4 * w), 3'd2, 4'(w), $urandom, 0);
      wr_chk(d, BASE + 32'h3FFC, 3'd2, 4'd9, 32'hCAFE_F00D, 0);
    end

    wr_chk(0, 32'h8000_0010, 3'd2, 4'd3, 32'h1234_5678, 0);
    rd_chk(0, 32'h8000_0010, 3'd2, 4'd5, 0);
    check("word_rd", mdl_rd(0, 32'h8000_0010, 3'd2), 32'h1234_5678);

    wr_chk(0, 32'h8000_0010, 3'd2, 4'd1, 32'hFFFF_FFFF, 0);
    wr_chk(0, 32'h8000_0012, 3'd0, 4'd2, 32'h00AB_0000, 1);
    rd_chk(0, 32'h8000_0010, 3'd2, 4'd7, 0);

    rd_chk(1, 32'h8000_0010, 3'd2, 4'd6, 3);

    wr_chk(0, 32'h7FFF_FFFC, 3'd2, 4'd4, 32'h5555_AAAA, 0);
    rd_chk(0, 32'h7FFF_FFFC, 3'd2, 4'd8, 0);
    rd_chk(0, BASE + 32'h3FFC, 3'd2, 4'd8, 0);
    wr_chk(0, BASE + 32'h4000, 3'd2, 4'd4, 32'h6666_7777, 0);
    rd_chk(0, BASE, 3'd2, 4'd8, 0);

    wr_chk(0, 32'h8000_0001, 3'd1, 4'd10, 32'h00BE_EF00, 0);
    rd_chk(0, 32'h8000_0000, 3'd2, 4'd11, 0);
    rd_chk(0, 32'h8000_0002, 3'd2, 4'd12, 0);

    // Read handshake on the same edge as a write commit to the same word.
    old_w = mdl[0][6];
    new_w = ~old_w ^ 32'h0F0F_0F0F;
    awvalid[0] = 1'b1; awaddr[0] = BASE + 32'h18; awsize[0] = 3'd2; awid[0] = 4'd1;
    @(negedge clk);
    awvalid[0] = 1'b0;
    check("col_wready", 32'(wready[0]), 32'd1);
    check("col_arready", 32'(arready[0]), 32'd1);
    wvalid[0] = 1'b1; wdata[0] = new_w;
    arvalid[0] = 1'b1; araddr[0] = BASE + 32'h18; arsize[0] = 3'd2; arid[0] = 4'd2;
    @(negedge clk);
    wvalid[0] = 1'b0; arvalid[0] = 1'b0;
    check("col_rvalid", 32'(rvalid[0]), 32'd1);
    check("col_old", rdata[0], old_w);
    check("col_bvalid", 32'(bvalid[0]), 32'd1);
    rready[0] = 1'b1; bready[0] = 1'b1;
    @(negedge clk);
    rready[0] = 1'b0; bready[0] = 1'b0;
    mdl[0][6] = new_w;
    rd_chk(0, BASE + 32'h18, 3'd2, 4'd3, 0);

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 30; k++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
        else if (r == 1) a = BASE + 32'h4000 + 32'($urandom_range(0, 63));
        else             a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        s = 3'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0)
          wr_chk(d, a, s, 4'($urandom), $urandom, $urandom_range(0, 2));
        else
          rd_chk(d, a, s, 4'($urandom), $urandom_range(0, 2));
      end
    end

    // Reset while the slow read is still counting: the response is dropped.
    arvalid[1] = 1'b1; araddr[1] = BASE; arsize[1] = 3'd2; arid[1] = 4'd5;
    check("mid_arready", 32'(arready[1]), 32'd1);
    @(negedge clk);
    arvalid[1] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check("mid_rvalid", 32'(rvalid[1]), 32'd0);
      check("mid_arready_post", 32'(arready[1]), 32'd1);
      @(negedge clk);
    end
    rd_chk(1, BASE, 3'd2, 4'd6, 0);
    rd_chk(0, BASE + 32'h18, 3'd2, 4'd7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
